// File: rtl/ft245_async_bridge_pkg.sv
// ---------------------------------------------------------------------------
// ft245_async_bridge_pkg
//  Shared definitions for the FT245 asynchronous FIFO bridge: data bus width,
//  strobe FSM state encoding and a small elaboration-time helper.
// ---------------------------------------------------------------------------
package ft245_async_bridge_pkg;

    localparam int BUS_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RD_STROBE = 3'd1,
        ST_WR_SETUP  = 3'd2,
        ST_WR_STROBE = 3'd3,
        ST_RECOVER   = 3'd4
    } state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ft245_async_bridge_sync_fifo.sv
// ---------------------------------------------------------------------------
// ft245_async_bridge_sync_fifo
//  Single-clock first-word-fall-through FIFO with a registered occupancy
//  count. The head entry is always visible on 'head' while not_empty is high.
//  Ports:
//   clock, reset      clock, async active-high reset
//   push, push_data   write request (ignored when full)
//   pop               read request (ignored when empty)
//   head              current head entry
//   not_empty         head valid
//   not_full          room for another push
//   count             occupancy, 0..DEPTH
// ---------------------------------------------------------------------------
module ft245_async_bridge_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     not_empty,
    output logic                     not_full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic             do_push;
    logic             do_pop;

    // Full/empty gating makes push-on-full and pop-on-empty harmless; a
    // push+pop on an empty FIFO therefore degrades to a push only.
    assign do_push = push && (count_reg != (AW+1)'(DEPTH));
    assign do_pop  = pop  && (count_reg != '0);

    // Pointers are AW bits wide, so they wrap modulo DEPTH by themselves.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Storage carries no reset so it can map onto distributed RAM.
    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr_reg] <= push_data;
    end

    assign head      = mem[rd_ptr_reg];
    assign not_empty = (count_reg != '0);
    assign not_full  = (count_reg != (AW+1)'(DEPTH));
    assign count     = count_reg;

endmodule

// File: rtl/ft245_async_bridge.sv
// ---------------------------------------------------------------------------
// ft245_async_bridge
//  Bridge between an FT2232H channel in asynchronous FT245 FIFO mode and
//  synchronous on-chip logic. Received bytes land in an RX FIFO, queued bytes
//  drain from a TX FIFO; a strobe FSM paces rd_n/wr_n by cycle counts.
//  Ports:
//   clock               system clock (posedge)
//   reset               async active-high reset
//   rxf_n / txe_n       FT status flags (async, synchronised here)
//   rd_n / wr_n         FT strobes, active low
//   data                FT bidirectional data bus
//   rx_data/rx_valid/rx_ready   RX FIFO head, valid/ready pop handshake
//   tx_data/tx_valid/tx_ready   TX FIFO push, valid/ready handshake
//   rx_count / tx_count FIFO occupancies
// ---------------------------------------------------------------------------
module ft245_async_bridge
    import ft245_async_bridge_pkg::*;
#(
    parameter int RX_DEPTH    = 16,
    parameter int TX_DEPTH    = 16,
    parameter int SYNC_STAGES = 2,
    parameter int RD_PULSE    = 2,
    parameter int WR_SETUP    = 1,
    parameter int WR_PULSE    = 2,
    parameter int RECOVER_CYC = 1
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        rxf_n,
    input  logic                        txe_n,
    output logic                        rd_n,
    output logic                        wr_n,
    inout  wire  [BUS_W-1:0]            data,
    output logic [BUS_W-1:0]            rx_data,
    output logic                        rx_valid,
    input  logic                        rx_ready,
    input  logic [BUS_W-1:0]            tx_data,
    input  logic                        tx_valid,
    output logic                        tx_ready,
    output logic [$clog2(RX_DEPTH):0]   rx_count,
    output logic [$clog2(TX_DEPTH):0]   tx_count
);

    // Recovery must outlast the synchroniser so a flag that has already
    // deasserted at the pin cannot launch a duplicate transaction.
    localparam int REC_CYC = max_int(RECOVER_CYC, SYNC_STAGES + 1);
    localparam int CNT_W   = 8;

    localparam logic [CNT_W-1:0] RD_LAST    = CNT_W'(RD_PULSE - 1);
    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(WR_SETUP - 1);
    localparam logic [CNT_W-1:0] WR_LAST    = CNT_W'(WR_PULSE - 1);
    localparam logic [CNT_W-1:0] REC_LAST   = CNT_W'(REC_CYC - 1);

    // ---------------- reset: async assert, synchronous release -------------
    logic [1:0] rst_pipe_reg;
    logic       rst_int;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) rst_pipe_reg <= 2'b11;
        else       rst_pipe_reg <= {rst_pipe_reg[0], 1'b0};
    end

    assign rst_int = rst_pipe_reg[1];

    // ---------------- flag synchronisers (reset to "not ready") -----------
    logic [SYNC_STAGES-1:0] rxf_sync_reg;
    logic [SYNC_STAGES-1:0] txe_sync_reg;
    logic                   rxf_s;
    logic                   txe_s;

    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                always_ff @(posedge clock or posedge rst_int) begin
                    if (rst_int) begin
                        rxf_sync_reg[0] <= 1'b1;
                        txe_sync_reg[0] <= 1'b1;
                    end else begin
                        rxf_sync_reg[0] <= rxf_n;
                        txe_sync_reg[0] <= txe_n;
                    end
                end
            end else begin : g_next
                always_ff @(posedge clock or posedge rst_int) begin
                    if (rst_int) begin
                        rxf_sync_reg[gi] <= 1'b1;
                        txe_sync_reg[gi] <= 1'b1;
                    end else begin
                        rxf_sync_reg[gi] <= rxf_sync_reg[gi-1];
                        txe_sync_reg[gi] <= txe_sync_reg[gi-1];
                    end
                end
            end
        end
    endgenerate

    assign rxf_s = rxf_sync_reg[SYNC_STAGES-1];
    assign txe_s = txe_sync_reg[SYNC_STAGES-1];

    // ---------------- FIFOs ------------------------------------------------
    state_t           state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             rd_n_reg;
    logic             wr_n_reg;
    logic             bus_oe_reg;
    logic [BUS_W-1:0] bus_out_reg;
    logic             prefer_rd_reg;

    logic             rx_push;
    logic             rx_not_full;
    logic             tx_pop;
    logic             tx_not_empty;
    logic [BUS_W-1:0] tx_head;

    // The bus is captured straight into FIFO storage on the last low cycle
    // of rd_n, so the byte is visible on rx_data one cycle later.
    assign rx_push = (state_reg == ST_RD_STROBE) && (cnt_reg == RD_LAST);
    // TX head retires on the same edge that returns wr_n high.
    assign tx_pop  = (state_reg == ST_WR_STROBE) && (cnt_reg == WR_LAST);

    ft245_async_bridge_sync_fifo #(
        .WIDTH (BUS_W),
        .DEPTH (RX_DEPTH)
    ) u_rx_fifo (
        .clock     (clock),
        .reset     (rst_int),
        .push      (rx_push),
        .push_data (data),
        .pop       (rx_ready),
        .head      (rx_data),
        .not_empty (rx_valid),
        .not_full  (rx_not_full),
        .count     (rx_count)
    );

    ft245_async_bridge_sync_fifo #(
        .WIDTH (BUS_W),
        .DEPTH (TX_DEPTH)
    ) u_tx_fifo (
        .clock     (clock),
        .reset     (rst_int),
        .push      (tx_valid),
        .push_data (tx_data),
        .pop       (tx_pop),
        .head      (tx_head),
        .not_empty (tx_not_empty),
        .not_full  (tx_ready),
        .count     (tx_count)
    );

    // ---------------- strobe FSM -------------------------------------------
    logic rd_ok;
    logic wr_ok;

    assign rd_ok = !rxf_s && rx_not_full;
    assign wr_ok = !txe_s && tx_not_empty;

    always_ff @(posedge clock or posedge rst_int) begin
        if (rst_int) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= '0;
            rd_n_reg      <= 1'b1;
            wr_n_reg      <= 1'b1;
            bus_oe_reg    <= 1'b0;
            bus_out_reg   <= '0;
            prefer_rd_reg <= 1'b1;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    cnt_reg <= '0;
                    // On a tie the type opposite to the last completed
                    // transaction goes first.
                    if (rd_ok && (!wr_ok || prefer_rd_reg)) begin
                        state_reg <= ST_RD_STROBE;
                        rd_n_reg  <= 1'b0;
                    end else if (wr_ok) begin
                        state_reg   <= ST_WR_SETUP;
                        bus_oe_reg  <= 1'b1;
                        bus_out_reg <= tx_head;
                    end
                end
                ST_RD_STROBE: begin
                    if (cnt_reg == RD_LAST) begin
                        rd_n_reg      <= 1'b1;
                        state_reg     <= ST_RECOVER;
                        cnt_reg       <= '0;
                        prefer_rd_reg <= 1'b0;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                ST_WR_SETUP: begin
                    if (cnt_reg == SETUP_LAST) begin
                        wr_n_reg  <= 1'b0;
                        state_reg <= ST_WR_STROBE;
                        cnt_reg   <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                ST_WR_STROBE: begin
                    if (cnt_reg == WR_LAST) begin
                        wr_n_reg      <= 1'b1;
                        state_reg     <= ST_RECOVER;
                        cnt_reg       <= '0;
                        prefer_rd_reg <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                ST_RECOVER: begin
                    // Dropping the enable here leaves the write data on the
                    // bus for exactly the first recovery cycle (hold).
                    bus_oe_reg <= 1'b0;
                    if (cnt_reg == REC_LAST) begin
                        state_reg <= ST_IDLE;
                        cnt_reg   <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    cnt_reg   <= '0;
                end
            endcase
        end
    end

    assign rd_n = rd_n_reg;
    assign wr_n = wr_n_reg;
    assign data = bus_oe_reg ? bus_out_reg : {BUS_W{1'bz}};

endmodule

// File: tb/tb_ft245_async_bridge.sv
module tb_ft245_async_bridge;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       rxf_n = 1'b1;
    logic       txe_n = 1'b1;
    logic       rd_n;
    logic       wr_n;
    wire  [7:0] data;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready = 1'b0;
    logic [7:0] tx_data  = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic [4:0] rx_count;
    logic [4:0] tx_count;

    always #5 clock = ~clock;

    ft245_async_bridge dut (
        .clock    (clock),
        .reset    (reset),
        .rxf_n    (rxf_n),
        .txe_n    (txe_n),
        .rd_n     (rd_n),
        .wr_n     (wr_n),
        .data     (data),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .rx_count (rx_count),
        .tx_count (tx_count)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- FT chip model ----------------------------------------
    // The FT side offers bytes ft_src[ft_idx..ft_len-1]; it drives the bus
    // whenever rd_n is low and consumes a byte when rd_n returns high.
    logic [7:0] ft_src [256];
    int         ft_len = 0;     // written by stimulus only
    int         ft_idx = 0;     // written by monitor only
    logic       rx_en  = 1'b0;
    logic       tx_en  = 1'b0;
    logic [7:0] ft_head = 8'h00;

    assign data = (rd_n == 1'b0) ? ft_head : 8'bz;

    // ---------------- bridge reference model -------------------------------
    logic [7:0] rx_q[$];
    logic [7:0] tx_q[$];
    logic [7:0] rx_popped[$];
    logic [7:0] ft_written[$];
    logic [7:0] txn_log[$];
    int         rd_pulses = 0;
    int         wr_pulses = 0;
    int         rd_low = 0;
    int         wr_low = 0;
    logic       prev_rd = 1'b1;
    logic       prev_wr = 1'b1;
    logic       prev_oe = 1'b0;
    logic       prev2_oe = 1'b0;
    logic [7:0] prev_data = 8'h00;
    logic       hold_prev = 1'b0;
    logic       setup_prev = 1'b0;
    logic       pend_pop = 1'b0;
    logic       pend_push = 1'b0;
    logic [7:0] pend_data = 8'h00;
    logic       mon_oe;
    logic [7:0] mon_head;
    logic       hold_now;

    always @(negedge clock) begin
        mon_oe = dut.bus_oe_reg;
        if (reset) begin
            chk("reset_rd_n", int'(rd_n), 1);
            chk("reset_wr_n", int'(wr_n), 1);
            chk("reset_bus_released", int'(mon_oe), 0);
            rx_q.delete();
            tx_q.delete();
            ft_idx   = ft_len;   // a partially strobed byte is dropped
            rd_low   = 0;
            wr_low   = 0;
            hold_prev  = 1'b0;
            setup_prev = 1'b0;
        end else begin
            chk("strobe_overlap", int'(!rd_n && !wr_n), 0);
            chk("bus_driven_during_rd", int'(!rd_n && mon_oe), 0);

            // read side: a new pulse needs a real byte at the FT and room
            if (prev_rd && !rd_n) begin
                chk("rd_start_has_byte", int'(ft_idx < ft_len), 1);
                chk("rd_start_has_room", int'(rx_q.size() < 16), 1);
                rd_low = 0;
            end
            if (!rd_n) rd_low++;
            if (pend_pop && rx_q.size() != 0) begin
                rx_popped.push_back(rx_q[0]);
                void'(rx_q.pop_front());
            end
            if (!prev_rd && rd_n) begin
                chk("rd_pulse_len", rd_low, 2);
                rx_q.push_back(ft_src[ft_idx[7:0]]);
                ft_idx++;
                rd_pulses++;
                txn_log.push_back(8'h52);   // 'R'
            end

            // write side
            if (pend_push) tx_q.push_back(pend_data);
            mon_head = (tx_q.size() != 0) ? tx_q[0] : 8'h00;
            if (setup_prev) chk("setup_then_strobe", int'(!wr_n), 1);
            if (hold_prev)  chk("bus_released_after_hold", int'(mon_oe), 0);
            if (prev_wr && !wr_n) begin
                chk("wr_start_has_byte", int'(tx_q.size() != 0), 1);
                chk("wr_setup_driven", int'(prev_oe), 1);
                chk("wr_setup_one_cycle", int'(prev2_oe), 0);
                chk("wr_setup_data", int'(prev_data), int'(mon_head));
                wr_low = 0;
            end
            if (!wr_n) begin
                wr_low++;
                chk("wr_strobe_driven", int'(mon_oe), 1);
                chk("wr_strobe_data", int'(data), int'(mon_head));
            end
            hold_now = !prev_wr && wr_n;
            if (hold_now) begin
                chk("wr_pulse_len", wr_low, 2);
                chk("wr_hold_driven", int'(mon_oe), 1);
                chk("wr_hold_data", int'(data), int'(mon_head));
                ft_written.push_back(mon_head);
                if (tx_q.size() != 0) void'(tx_q.pop_front());
                wr_pulses++;
                txn_log.push_back(8'h57);   // 'W'
            end
            hold_prev  = hold_now;
            setup_prev = mon_oe && wr_n && !hold_now;

            // FIFO-facing outputs
            chk("rx_valid", int'(rx_valid), int'(rx_q.size() != 0));
            chk("rx_count", int'(rx_count), rx_q.size());
            if (rx_q.size() != 0) chk("rx_data", int'(rx_data), int'(rx_q[0]));
            chk("tx_count", int'(tx_count), tx_q.size());
            chk("tx_ready", int'(tx_ready), int'(tx_q.size() < 16));
        end

        ft_head   = (ft_idx < ft_len) ? ft_src[ft_idx[7:0]] : 8'h00;
        rxf_n     = !(rx_en && (ft_idx < ft_len));
        txe_n     = !tx_en;
        pend_pop  = rx_valid && rx_ready && !reset;
        pend_push = tx_valid && tx_ready && !reset;
        pend_data = tx_data;
        prev2_oe  = prev_oe;
        prev_oe   = mon_oe;
        prev_data = data;
        prev_rd   = rd_n;
        prev_wr   = wr_n;
    end

    // ---------------- stimulus ---------------------------------------------
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic offer(input logic [7:0] b);
        ft_src[ft_len[7:0]] = b;
        ft_len++;
    endtask

    logic [7:0] exp_pat [12];

    initial begin
        int k;
        int base_rd;
        int base_wr;
        int base_log;
        int base_pop;
        int base_out;
        int tx_idx;
        logic fire;

        // reset state
        reset = 1'b1;
        repeat (3) step();
        reset = 1'b0;
        repeat (4) step();
        chk("init_rd_n", int'(rd_n), 1);
        chk("init_wr_n", int'(wr_n), 1);
        chk("init_rx_valid", int'(rx_valid), 0);
        chk("init_tx_ready", int'(tx_ready), 1);
        chk("init_rx_count", int'(rx_count), 0);
        chk("init_tx_count", int'(tx_count), 0);

        // single read with latency measurement
        base_rd = rd_pulses;
        offer(8'hA5);
        rx_en = 1'b1;
        k = 0;
        while (rxf_n && k < 5) begin step(); k++; end
        // rxf_n fell at the negedge before this point: one posedge elapsed
        k = 1;
        while (rd_n && k < 20) begin step(); k++; end
        chk("rd_latency_cycles", k, 3);
        repeat (30) step();
        chk("single_read_pulses", rd_pulses - base_rd, 1);
        chk("single_read_rx_data", int'(rx_data), 8'hA5);
        chk("single_read_rx_valid", int'(rx_valid), 1);
        chk("single_read_rx_count", int'(rx_count), 1);
        rx_ready = 1'b1; step(); rx_ready = 1'b0;
        step();
        chk("single_read_popped", int'(rx_count), 0);

        // RX backpressure
        base_rd = rd_pulses;
        for (int i = 0; i < 20; i++) offer(8'h20 + 8'(i));
        repeat (150) step();
        chk("bp_reads_when_full", rd_pulses - base_rd, 16);
        chk("bp_rx_count_full", int'(rx_count), 16);
        chk("bp_rd_n_idle", int'(rd_n), 1);
        rx_ready = 1'b1; step(); rx_ready = 1'b0;
        repeat (40) step();
        chk("bp_one_more_read", rd_pulses - base_rd, 17);
        rx_ready = 1'b1;
        repeat (100) step();
        rx_ready = 1'b0;
        step();
        chk("bp_all_reads", rd_pulses - base_rd, 20);
        chk("bp_drained", int'(rx_count), 0);
        rx_en = 1'b0;

        // single write
        base_wr = wr_pulses;
        tx_valid = 1'b1; tx_data = 8'h3C; step(); tx_valid = 1'b0;
        chk("wr_queued_count", int'(tx_count), 1);
        tx_en = 1'b1;
        repeat (30) step();
        chk("wr_pulses", wr_pulses - base_wr, 1);
        chk("wr_tx_count_after", int'(tx_count), 0);
        chk("wr_byte_on_bus", (ft_written.size() != 0) ? int'(ft_written[ft_written.size()-1]) : -1, 8'h3C);
        tx_en = 1'b0;
        step();

        // reset in the middle of a read strobe
        offer(8'h77);
        rx_en = 1'b1;
        k = 0;
        while (rd_n && k < 20) begin step(); k++; end
        chk("midrd_reached_strobe", int'(rd_n), 0);
        reset = 1'b1;
        #1;
        chk("midrd_rd_n_released", int'(rd_n), 1);
        chk("midrd_bus_released", int'(dut.bus_oe_reg), 0);
        rx_en = 1'b0;
        repeat (3) step();
        reset = 1'b0;
        repeat (4) step();
        chk("midrd_rx_count", int'(rx_count), 0);
        chk("midrd_tx_count", int'(tx_count), 0);
        chk("midrd_tx_ready", int'(tx_ready), 1);
        chk("midrd_rx_valid", int'(rx_valid), 0);

        // arbitration: 8 RX bytes pending, 4 TX bytes queued
        exp_pat = '{8'h52, 8'h57, 8'h52, 8'h57, 8'h52, 8'h57, 8'h52, 8'h57,
                    8'h52, 8'h52, 8'h52, 8'h52};
        base_log = txn_log.size();
        for (int i = 0; i < 4; i++) begin
            tx_valid = 1'b1; tx_data = 8'h50 + 8'(i); step();
        end
        tx_valid = 1'b0;
        for (int i = 0; i < 8; i++) offer(8'h60 + 8'(i));
        rx_en = 1'b1;
        tx_en = 1'b1;
        repeat (200) step();
        chk("arb_txn_count", txn_log.size() - base_log, 12);
        for (int i = 0; i < 12; i++) begin
            if (base_log + i < txn_log.size())
                chk($sformatf("arb_order_%0d", i), int'(txn_log[base_log + i]), int'(exp_pat[i]));
        end
        rx_ready = 1'b1;
        repeat (40) step();
        rx_ready = 1'b0;
        rx_en = 1'b0;
        tx_en = 1'b0;
        step();

        // streaming with random handshakes
        base_pop = rx_popped.size();
        base_out = ft_written.size();
        for (int i = 0; i < 40; i++) offer(8'h40 + 8'(i));
        rx_en = 1'b1;
        tx_en = 1'b1;
        tx_idx = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (tx_idx == 40 && rx_popped.size() - base_pop == 40 &&
                ft_written.size() - base_out == 40) break;
            @(negedge clock);
            fire = tx_valid && tx_ready;
            @(posedge clock);
            #1;
            if (fire) tx_idx++;
            tx_valid = (tx_idx < 40) && ($urandom_range(0, 1) == 1);
            tx_data  = 8'h80 + tx_idx[7:0];
            rx_ready = ($urandom_range(0, 1) == 1);
        end
        tx_valid = 1'b0;
        rx_ready = 1'b0;
        chk("wrap_rx_total", rx_popped.size() - base_pop, 40);
        chk("wrap_tx_total", ft_written.size() - base_out, 40);
        for (int i = 0; i < 40; i++) begin
            if (base_pop + i < rx_popped.size())
                chk($sformatf("wrap_rx_%0d", i), int'(rx_popped[base_pop + i]), 8'h40 + i);
            if (base_out + i < ft_written.size())
                chk($sformatf("wrap_tx_%0d", i), int'(ft_written[base_out + i]), 8'h80 + i);
        end
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
